// File: rtl/mdu_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer: md_op codes and FSM states.
// Pure definitions: no latency, no backpressure.
package mdu_ctrl_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_t;

endpackage

// File: rtl/mdu_calc.sv
// Combinational HI/LO result generator for mult/multu/div/divu; res_wr=0 marks a zero divisor.
// Zero latency, no backpressure; a future iterative divider drops in behind the same ports.
module mdu_calc
  import mdu_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        res_wr
);

  logic [63:0] prod;
  logic [31:0] a_mag, b_mag, dvs, q_mag, r_mag;
  logic        sgn_div;

  always_comb begin
    prod    = 64'd0;
    sgn_div = (op == MD_DIV);
    // Signed divide runs on magnitudes, so INT_MIN / -1 wraps back to INT_MIN with no trap.
    a_mag   = (sgn_div && rs[31]) ? (32'd0 - rs) : rs;
    b_mag   = (sgn_div && rt[31]) ? (32'd0 - rt) : rt;
    dvs     = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag   = a_mag / dvs;
    r_mag   = a_mag % dvs;
    res_hi  = 32'd0;
    res_lo  = 32'd0;
    res_wr  = 1'b1;
    case (op)
      MD_MULT: begin
        prod = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
        {res_hi, res_lo} = prod;
      end
      MD_MULTU: begin
        prod = {32'd0, rs} * {32'd0, rt};
        {res_hi, res_lo} = prod;
      end
      MD_DIV: begin
        res_lo = (rs[31] ^ rt[31]) ? (32'd0 - q_mag) : q_mag;
        res_hi = rs[31] ? (32'd0 - r_mag) : r_mag;
        res_wr = (rt != 32'd0);
      end
      MD_DIVU: begin
        res_lo = q_mag;
        res_hi = r_mag;
        res_wr = (rt != 32'd0);
      end
      default: res_wr = 1'b0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// HI/LO owner and mult/div sequencer: busy for MULT_CYCLES/DIV_CYCLES after issue, results commit as busy drops.
// No backpressure: starts while busy are dropped, md_stall holds D; MDU_DIVZERO_FAST_EN makes divide-by-zero 1 cycle.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_in_D,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;
  logic [31:0] calc_hi, calc_lo;
  logic        calc_wr, is_mul, is_div, issue_long;

  assign is_mul     = (md_op == MD_MULT) || (md_op == MD_MULTU);
  assign is_div     = (md_op == MD_DIV)  || (md_op == MD_DIVU);
  assign issue_long = start && (is_mul || is_div);

  mdu_calc u_calc (
    .op     (md_op),
    .rs     (rs_val),
    .rt     (rt_val),
    .res_hi (calc_hi),
    .res_lo (calc_lo),
    .res_wr (calc_wr)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= MDU_IDLE;
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      MDU_IDLE: begin
        if (issue_long) begin
          pend_hi_d = calc_hi;
          pend_lo_d = calc_lo;
          pend_wr_d = calc_wr;
          cnt_d     = is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
`ifdef MDU_DIVZERO_FAST_EN
          if (!calc_wr) cnt_d = 4'd1;
`endif
          state_d   = MDU_BUSY;
        end else if (start && md_op == MD_MTHI) begin
          hi_d = rs_val;
        end else if (start && md_op == MD_MTLO) begin
          lo_d = rs_val;
        end
      end
      MDU_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          // A zero divisor leaves pend_wr clear, so HI/LO survive the commit edge.
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          state_d = MDU_IDLE;
        end
      end
    endcase
  end

  assign busy     = (state_q == MDU_BUSY);
  assign md_stall = md_in_D && (busy || issue_long);
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed + randomized check of mdu_ctrl against a longint arithmetic reference model.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, md_in_D;
  logic [2:0]  md_op;
  logic [31:0] rs_val, rt_val;
  logic        busy, md_stall;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] mdl_hi, mdl_lo;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .md_in_D  (md_in_D),
    .busy     (busy),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural effect of one instruction, from plain 64-bit arithmetic.
  task automatic ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic [31:0] eh, output logic [31:0] el);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    eh = mdl_hi;
    el = mdl_lo;
    lat = 0;
    case (op)
      3'd1: begin q = sa * sb; {eh, el} = q; lat = 5; end
      3'd2: begin up = ua * ub; {eh, el} = up; lat = 5; end
      3'd3, 3'd4: begin
        lat = 10;
        if (b == 32'd0) begin
`ifdef MDU_DIVZERO_FAST_EN
          lat = 1;
`endif
        end else if (op == 3'd3) begin
          q = sa / sb; r = sa % sb;
          el = q[31:0]; eh = r[31:0];
        end else begin
          uq = ua / ub; ur = ua % ub;
          el = uq[31:0]; eh = ur[31:0];
        end
      end
      3'd5: eh = a;
      3'd6: el = a;
      default: ;
    endcase
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic d, input bit inject);
    int lat, n;
    logic [31:0] eh, el;
    ref_model(op, a, b, lat, eh, el);
    @(negedge clk);
    start = 1'b1; md_op = op; rs_val = a; rt_val = b; md_in_D = d;
    #1;
    check("stall_issue", {31'd0, md_stall}, {31'd0, d && (lat > 0)});
    @(negedge clk);
    start = 1'b0; md_op = MD_NONE;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      if (d) check("stall_busy", {31'd0, md_stall}, 32'd1);
      n++;
      if (inject && n == 1) begin
        start = 1'b1; md_op = MD_DIV; rs_val = 32'd100; rt_val = 32'd7;
      end else if (inject && n == 2) begin
        start = 1'b0; md_op = MD_NONE;
      end
      @(negedge clk);
    end
    check("latency", 32'(n), 32'(lat));
    check("stall_after", {31'd0, md_stall}, 32'd0);
    check("hi", hi, eh);
    check("lo", lo, el);
    mdl_hi = eh;
    mdl_lo = el;
    md_in_D = 1'b0;
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    reset = 1'b0; start = 1'b0; md_op = MD_NONE;
    rs_val = 32'd0; rt_val = 32'd0; md_in_D = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stall", {31'd0, md_stall}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b1; md_in_D = 1'b0;
    mdl_hi = 32'd0; mdl_lo = 32'd0;

    do_op(MD_MULT,  32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
    check("mult_hi_const", hi, 32'hFFFF_FFFF);
    check("mult_lo_const", lo, 32'hFFFF_FFFE);
    do_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    check("multu_hi_const", hi, 32'h0000_0001);
    do_op(MD_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    check("div_lo_const", lo, 32'hFFFF_FFFD);
    check("div_hi_const", hi, 32'hFFFF_FFFF);
    do_op(MD_DIVU,  32'd7, 32'd2, 1'b0, 1'b0);
    do_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("ovf_lo_const", lo, 32'h8000_0000);
    check("ovf_hi_const", hi, 32'd0);
    do_op(MD_MTHI,  32'h1234, 32'd0, 1'b1, 1'b0);
    do_op(MD_MTLO,  32'h5678, 32'd0, 1'b0, 1'b0);
    do_op(MD_DIV,   32'd99, 32'd0, 1'b1, 1'b0);
    check("div0_hi_const", hi, 32'h1234);
    check("div0_lo_const", lo, 32'h5678);
    do_op(MD_DIVU,  32'd99, 32'd0, 1'b0, 1'b0);
    do_op(MD_MULT,  32'd6, 32'd7, 1'b1, 1'b1);
    do_op(3'd7,     32'h1111, 32'h2222, 1'b1, 1'b0);
    do_op(MD_NONE,  32'h3333, 32'h4444, 1'b0, 1'b0);

    // Abort in the third busy cycle: HI/LO return to zero, pending product discarded.
    do_op(MD_MTHI, 32'hAAAA_5555, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1; md_op = MD_MULT; rs_val = 32'd3; rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0; md_op = MD_NONE;
    repeat (2) @(negedge clk);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    reset = 1'b1;
    mdl_hi = 32'd0; mdl_lo = 32'd0;
    repeat (6) @(negedge clk);
    check("abort_no_commit", lo, 32'd0);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
      do_op(rop, ra, rb, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
